radio_seq_ctrl: RTL and testbench

- Sits between the bt_top baseband outputs (txbit, nxtfk, fk_chg_p_ff, txbit_period, rxbit_period) and the RF front end or radio model.
- Latches each new hop frequency and times the PLL settling window from regi_pllsetuptime.
- Gates the PA and LNA enables; transmit is blocked until the synthesiser has settled.
- Recovers 1 Mbps receive bits from the 6 MHz oversampled RF receive line with mid-cell majority voting.

---
 rtl/radio_seq_if.sv | 31 +++
 rtl/radio_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_radio_seq_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/radio_seq_if.sv
// Baseband <-> radio sequencer signal bundle.
// The sequencer is the slave; the baseband/radio side is the master.
interface radio_seq_if;
    logic [9:0] regi_pllsetuptime;
    logic [6:0] lc_fk;
    logic       loadfreq_p;
    logic       txen;
    logic       rxen;
    logic       txbitin;
    logic       rf_rxbit;
    logic [6:0] rf_fk;
    logic       rf_pll_lock;
    logic       rf_pa_en;
    logic       rf_lna_en;
    logic       rf_txbit;
    logic       rxbitout;
    logic       rxbit_valid_p;
    logic       pll_err_p;

    modport master (
        output regi_pllsetuptime, lc_fk, loadfreq_p, txen, rxen, txbitin, rf_rxbit,
        input  rf_fk, rf_pll_lock, rf_pa_en, rf_lna_en, rf_txbit, rxbitout,
               rxbit_valid_p, pll_err_p
    );

    modport slave (
        input  regi_pllsetuptime, lc_fk, loadfreq_p, txen, rxen, txbitin, rf_rxbit,
        output rf_fk, rf_pll_lock, rf_pa_en, rf_lna_en, rf_txbit, rxbitout,
               rxbit_valid_p, pll_err_p
    );
endinterface

// File: rtl/radio_seq_ctrl.sv
// Radio sequencer: hop-frequency latch, PLL settle timer, PA/LNA gating and
// mid-cell majority-vote recovery of oversampled receive bits.
module radio_seq_ctrl #(
    parameter int CLKS_PER_US  = 6,
    parameter int CLKS_PER_BIT = 6,
    parameter int CNT_W        = 13
) (
    input  logic        clk_6M,
    input  logic        rstz,
    radio_seq_if.slave  bus
);
    localparam int PH_W = $clog2(CLKS_PER_BIT);
    localparam logic [PH_W-1:0] PH_LO   = PH_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [PH_W-1:0] PH_HI   = PH_W'(CLKS_PER_BIT/2 + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, LOCKED, TX, RX} state_t;

    state_t             state_q, state_d;
    logic [6:0]         fk_q, fk_d;
    logic               lock_q, lock_d;
    logic               pa_q, pa_d;
    logic               lna_q, lna_d;
    logic               txbit_q, txbit_d;
    logic               rxbit_q, rxbit_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [2:0]         samp_q, samp_d;
    logic               txen_q, rxen_q;
    logic               maj;

    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    always_comb begin
        state_d = state_q;
        fk_d    = fk_q;
        lock_d  = lock_q;
        pa_d    = pa_q;
        lna_d   = lna_q;
        rxbit_d = rxbit_q;
        vld_d   = 1'b0;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        samp_d  = samp_q;
        // Only a fresh rising request while unlocked is flagged; a held level is not.
        err_d   = ~lock_q & ((bus.txen & ~txen_q) | (bus.rxen & ~rxen_q));

        if (bus.loadfreq_p) begin
            fk_d    = bus.lc_fk;
            lock_d  = 1'b0;
            pa_d    = 1'b0;
            lna_d   = 1'b0;
            cnt_d   = CNT_W'(bus.regi_pllsetuptime) * CNT_W'(CLKS_PER_US);
            ph_d    = '0;
            samp_d  = '0;
            state_d = SETTLE;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == '0) begin
                        lock_d  = 1'b1;
                        state_d = LOCKED;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (bus.txen) begin
                        pa_d    = 1'b1;
                        state_d = TX;
                    end else if (bus.rxen) begin
                        lna_d   = 1'b1;
                        ph_d    = '0;
                        state_d = RX;
                    end
                end
                TX: begin
                    if (!bus.txen) begin
                        pa_d    = 1'b0;
                        state_d = LOCKED;
                    end
                end
                RX: begin
                    if (!bus.rxen) begin
                        lna_d   = 1'b0;
                        state_d = LOCKED;
                    end else begin
                        if (ph_q >= PH_LO && ph_q <= PH_HI)
                            samp_d = {samp_q[1:0], bus.rf_rxbit};
                        if (ph_q == PH_LAST) begin
                            rxbit_d = maj;
                            vld_d   = 1'b1;
                            ph_d    = '0;
                        end else begin
                            ph_d = ph_q + PH_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        txbit_d = pa_d & bus.txbitin;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            fk_q    <= '0;
            lock_q  <= 1'b0;
            pa_q    <= 1'b0;
            lna_q   <= 1'b0;
            txbit_q <= 1'b0;
            rxbit_q <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ph_q    <= '0;
            samp_q  <= '0;
            txen_q  <= 1'b0;
            rxen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fk_q    <= fk_d;
            lock_q  <= lock_d;
            pa_q    <= pa_d;
            lna_q   <= lna_d;
            txbit_q <= txbit_d;
            rxbit_q <= rxbit_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            samp_q  <= samp_d;
            txen_q  <= bus.txen;
            rxen_q  <= bus.rxen;
        end
    end

    assign bus.rf_fk         = fk_q;
    assign bus.rf_pll_lock   = lock_q;
    assign bus.rf_pa_en      = pa_q;
    assign bus.rf_lna_en     = lna_q;
    assign bus.rf_txbit      = txbit_q;
    assign bus.rxbitout      = rxbit_q;
    assign bus.rxbit_valid_p = vld_q;
    assign bus.pll_err_p     = err_q;
endmodule

// File: tb/tb_radio_seq_ctrl.sv
// Bench for radio_seq_ctrl: directed scenarios plus random traffic, all
// outputs compared every cycle against a timestamp/queue based reference.
module tb_radio_seq_ctrl;
    localparam int CPU = 6;
    localparam int CPB = 6;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;
    always #5 clk_6M = ~clk_6M;

    radio_seq_if bus();

    radio_seq_ctrl #(.CLKS_PER_US(CPU), .CLKS_PER_BIT(CPB), .CNT_W(13)) dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: lock time as an absolute edge number, RX cells as a queue of raw samples.
    logic [6:0] m_fk;
    logic       m_lock, m_pa, m_lna, m_txbit, m_rxbit, m_vld, m_err;
    int         mode;          // 0 none, 1 transmitting, 2 receiving
    longint     cyc, lock_edge;
    logic       ptx, prx;
    logic       rxq[$];
    int         ones;

    always @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            m_fk = '0; m_lock = 0; m_pa = 0; m_lna = 0; m_txbit = 0;
            m_rxbit = 0; m_vld = 0; m_err = 0; mode = 0; cyc = 0;
            lock_edge = -1; ptx = 0; prx = 0; rxq.delete();
        end else begin
            cyc++;
            m_vld = 0;
            m_err = !m_lock && ((bus.txen && !ptx) || (bus.rxen && !prx));
            ptx = bus.txen;
            prx = bus.rxen;
            if (bus.loadfreq_p) begin
                m_fk = bus.lc_fk; m_lock = 0; m_pa = 0; m_lna = 0; mode = 0;
                lock_edge = cyc + longint'(bus.regi_pllsetuptime) * CPU + 1;
            end else if (!m_lock) begin
                if (cyc == lock_edge) m_lock = 1;
            end else if (mode == 0) begin
                if (bus.txen) begin mode = 1; m_pa = 1; end
                else if (bus.rxen) begin mode = 2; m_lna = 1; rxq.delete(); end
            end else if (mode == 1) begin
                if (!bus.txen) begin mode = 0; m_pa = 0; end
            end else begin
                if (!bus.rxen) begin
                    mode = 0; m_lna = 0;
                end else begin
                    rxq.push_back(bus.rf_rxbit);
                    if (rxq.size() == CPB) begin
                        ones = int'(rxq[CPB/2-1]) + int'(rxq[CPB/2]) + int'(rxq[CPB/2+1]);
                        m_rxbit = (ones >= 2);
                        m_vld = 1;
                        rxq.delete();
                    end
                end
            end
            m_txbit = m_pa && bus.txbitin;
        end
    end

    function automatic logic [31:0] dut_outs();
        return 32'({bus.rf_fk, bus.rf_pll_lock, bus.rf_pa_en, bus.rf_lna_en, bus.rf_txbit,
                    bus.rxbitout, bus.rxbit_valid_p, bus.pll_err_p});
    endfunction

    task automatic tick();
        @(posedge clk_6M);
        #1;
        chk("outs", dut_outs(),
            32'({m_fk, m_lock, m_pa, m_lna, m_txbit, m_rxbit, m_vld, m_err}));
    endtask

    int n, strobes, vs;
    int pat[4] = '{1, 0, 1, 1};

    initial begin
        bus.regi_pllsetuptime = '0; bus.lc_fk = '0; bus.loadfreq_p = 0;
        bus.txen = 0; bus.rxen = 0; bus.txbitin = 0; bus.rf_rxbit = 0;
        repeat (3) @(posedge clk_6M);
        #1;
        chk("reset_outs", dut_outs(), 32'd0);
        rstz = 1;

        // Load channel 45 with 150 us setup
        bus.lc_fk = 7'd45; bus.regi_pllsetuptime = 10'd150; bus.loadfreq_p = 1;
        tick();
        bus.loadfreq_p = 0;
        chk("fk45", 32'(bus.rf_fk), 32'd45);
        chk("lock_low", 32'(bus.rf_pll_lock), 32'd0);
        n = 0;
        while (!bus.rf_pll_lock && n < 2000) begin tick(); n++; end
        chk("lock_lat", n, 901);

        // Zero setup, transmit window
        bus.regi_pllsetuptime = 10'd0; bus.loadfreq_p = 1;
        tick();
        bus.loadfreq_p = 0;
        tick();
        chk("lock0", 32'(bus.rf_pll_lock), 32'd1);
        tick(); tick();
        bus.txen = 1;
        for (int i = 0; i < 24; i++) begin
            bus.txbitin = 1'((i / 6) % 2);
            tick();
            if (i == 0) chk("pa_on", 32'(bus.rf_pa_en), 32'd1);
            chk("txbit", 32'(bus.rf_txbit), 32'(bus.txbitin));
        end
        bus.txen = 0;
        tick();
        chk("pa_off", 32'(bus.rf_pa_en), 32'd0);
        chk("txbit_off", 32'(bus.rf_txbit), 32'd0);

        // Receive 1,0,1,1 with a glitch on a sampled phase of the third bit
        bus.rxen = 1;
        tick();
        chk("lna_on", 32'(bus.rf_lna_en), 32'd1);
        strobes = 0;
        for (int b = 0; b < 4; b++) begin
            for (int p = 0; p < CPB; p++) begin
                bus.rf_rxbit = (b == 2 && p == 2) ? 1'(!pat[b]) : 1'(pat[b]);
                tick();
                if (bus.rxbit_valid_p) begin
                    strobes++;
                    chk("rxbit", 32'(bus.rxbitout), 32'(pat[b]));
                    chk("strobe_phase", p, CPB - 1);
                end
            end
        end
        chk("strobes", strobes, 4);
        bus.rxen = 0;
        tick();
        chk("lna_off", 32'(bus.rf_lna_en), 32'd0);

        // Request while unlocked
        bus.regi_pllsetuptime = 10'd150; bus.loadfreq_p = 1;
        tick();
        bus.loadfreq_p = 0;
        repeat (9) tick();
        bus.txen = 1;
        tick();
        chk("err_pulse", 32'(bus.pll_err_p), 32'd1);
        tick();
        chk("err_once", 32'(bus.pll_err_p), 32'd0);
        n = 0;
        while (!bus.rf_pll_lock && n < 2000) begin
            chk("pa_held", 32'(bus.rf_pa_en), 32'd0);
            tick(); n++;
        end
        chk("pa_at_lock", 32'(bus.rf_pa_en), 32'd0);
        tick();
        chk("pa_after_lock", 32'(bus.rf_pa_en), 32'd1);
        bus.txen = 0;
        tick();

        // Load mid-RX at phase 3
        bus.regi_pllsetuptime = 10'd0; bus.loadfreq_p = 1;
        tick();
        bus.loadfreq_p = 0;
        tick();
        bus.rxen = 1;
        tick();
        tick(); tick(); tick();
        bus.lc_fk = 7'd99; bus.loadfreq_p = 1;
        tick();
        bus.loadfreq_p = 0;
        chk("abort_lna", 32'(bus.rf_lna_en), 32'd0);
        chk("abort_fk", 32'(bus.rf_fk), 32'd99);
        chk("abort_lock", 32'(bus.rf_pll_lock), 32'd0);
        vs = 0;
        repeat (5) begin tick(); if (bus.rxbit_valid_p) vs++; end
        chk("no_partial", vs, 0);
        bus.rxen = 0;
        tick(); tick();

        // TX priority, then async reset mid-TX
        bus.txen = 1; bus.rxen = 1;
        tick();
        chk("prio_pa", 32'(bus.rf_pa_en), 32'd1);
        chk("prio_lna", 32'(bus.rf_lna_en), 32'd0);
        repeat (3) begin bus.txbitin = 1'($urandom); tick(); end
        bus.txbitin = 1;
        tick();
        #2 rstz = 0;
        #1;
        chk("async_rst", dut_outs(), 32'd0);
        bus.txen = 0; bus.rxen = 0;
        repeat (2) tick();
        rstz = 1;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bus.loadfreq_p = ($urandom_range(0, 199) == 0);
            bus.lc_fk = 7'($urandom);
            bus.regi_pllsetuptime = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 40))
                                                                : 10'($urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0) bus.txen = !bus.txen;
            if ($urandom_range(0, 39) == 0) bus.rxen = !bus.rxen;
            bus.txbitin  = 1'($urandom);
            bus.rf_rxbit = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
